// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Screen geometry, sprite size and state types shared by game blocks
// Revision : 1.0  initial release
// ============================================================================
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPR      = 16;

    // Sprite-local coordinate meaning "this pixel is not on the sprite"
    localparam logic [10:0] c_outside = 11'h7FF;

    typedef enum logic [1:0] {
        COIN_IDLE   = 2'd0,
        COIN_SPAWN  = 2'd1,
        COIN_ACTIVE = 2'd2,
        COIN_HIDDEN = 2'd3
    } coin_state_e;

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : lfsr8
// Purpose  : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), advances every cycle
// Revision : 1.0  initial release
// ============================================================================
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic       w_feedback;

    assign w_feedback = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= {q_q[6:0], w_feedback};
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/coin_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coin_ctrl
// Purpose  : Coin position/collect/respawn control and render-aligned ROM feed
// Revision : 1.0  initial release
// ============================================================================
module coin_ctrl #(
    parameter int         SCREEN_W       = game_pkg::SCREEN_W,
    parameter int         SPR            = game_pkg::SPR,
    parameter int         SPEED          = 2,
    parameter int         Y_MIN          = 64,
    parameter int         BIRD_W         = 24,
    parameter int         BIRD_H         = 16,
    parameter int         RESPAWN_FRAMES = 60,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        game_run,
    input  logic [10:0] vga_x,
    input  logic [10:0] vga_y,
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y,
    output logic [10:0] spr_x,
    output logic [10:0] spr_y,
    output logic        spr_en,
    output logic        coin_collect,
    output logic [7:0]  coin_count,
    output logic [10:0] coin_x,
    output logic [10:0] coin_y
);
    import game_pkg::*;

    localparam int HW = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES + 1) : 1;

    coin_state_e  state_q, state_d;
    logic [10:0]  coin_x_q, coin_x_d;
    logic [10:0]  coin_y_q, coin_y_d;
    logic [7:0]   count_q, count_d;
    logic         collect_q, collect_d;
    logic [HW-1:0] hide_q, hide_d;
    logic [7:0]   w_lfsr;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    // Widened to 12 bits so a coin parked at x = SCREEN_W cannot wrap
    function automatic logic boxes_overlap(
        input logic [10:0] cx,
        input logic [10:0] cy,
        input logic [10:0] bx,
        input logic [10:0] by
    );
        logic [11:0] cx_e, cy_e, bx_e, by_e;
        cx_e = {1'b0, cx};
        cy_e = {1'b0, cy};
        bx_e = {1'b0, bx};
        by_e = {1'b0, by};
        return (cx_e < bx_e + 12'(BIRD_W)) && (bx_e < cx_e + 12'(SPR)) &&
               (cy_e < by_e + 12'(BIRD_H)) && (by_e < cy_e + 12'(SPR));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COIN_IDLE;
            coin_x_q  <= 11'(SCREEN_W);
            coin_y_q  <= 11'(Y_MIN);
            count_q   <= 8'd0;
            collect_q <= 1'b0;
            hide_q    <= '0;
        end else begin
            state_q   <= state_d;
            coin_x_q  <= coin_x_d;
            coin_y_q  <= coin_y_d;
            count_q   <= count_d;
            collect_q <= collect_d;
            hide_q    <= hide_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        coin_x_d  = coin_x_q;
        coin_y_d  = coin_y_q;
        count_d   = count_q;
        collect_d = 1'b0;
        hide_d    = hide_q;
        if (game_run) begin
            case (state_q)
                COIN_IDLE: begin
                    state_d = COIN_SPAWN;
                end
                COIN_SPAWN: begin
                    coin_x_d = 11'(SCREEN_W);
                    coin_y_d = 11'(Y_MIN) + {3'b000, w_lfsr};
                    state_d  = COIN_ACTIVE;
                end
                COIN_ACTIVE: begin
                    if (frame_tick) begin
                        if (boxes_overlap(coin_x_q, coin_y_q, bird_x, bird_y)) begin
                            collect_d = 1'b1;
                            if (count_q != 8'hFF) begin
                                count_d = count_q + 8'd1;
                            end
                            hide_d  = HW'(RESPAWN_FRAMES);
                            state_d = COIN_HIDDEN;
                        end else if (coin_x_q <= 11'(SPEED)) begin
                            hide_d  = HW'(RESPAWN_FRAMES);
                            state_d = COIN_HIDDEN;
                        end else begin
                            coin_x_d = coin_x_q - 11'(SPEED);
                        end
                    end
                end
                COIN_HIDDEN: begin
                    if (frame_tick) begin
                        // The tick that takes the counter to zero is the respawn tick
                        if (hide_q <= HW'(1)) begin
                            hide_d  = '0;
                            state_d = COIN_SPAWN;
                        end else begin
                            hide_d = hide_q - HW'(1);
                        end
                    end
                end
                default: begin
                    state_d = COIN_IDLE;
                end
            endcase
        end
    end

    // Render pipeline: spr_y leads spr_x by one stage so the ROM's registered
    // row lookup lines up with spr_x/spr_en.
    logic [10:0] w_dx, w_dy;
    logic        w_visible, w_inbox;
    logic        inbox1_q;
    logic [10:0] dx1_q;
    logic [10:0] spr_x_q, spr_y_q;
    logic        spr_en_q;

    assign w_dx      = vga_x - coin_x_q;
    assign w_dy      = vga_y - coin_y_q;
    assign w_visible = (state_q == COIN_ACTIVE) || (state_q == COIN_SPAWN);
    assign w_inbox   = w_visible && (w_dx < 11'(SPR)) && (w_dy < 11'(SPR));

    always_ff @(posedge clk) begin
        if (rst) begin
            inbox1_q <= 1'b0;
            dx1_q    <= '0;
            spr_y_q  <= c_outside;
            spr_x_q  <= c_outside;
            spr_en_q <= 1'b0;
        end else begin
            inbox1_q <= w_inbox;
            dx1_q    <= w_dx;
            spr_y_q  <= w_inbox ? w_dy : c_outside;
            spr_x_q  <= inbox1_q ? dx1_q : c_outside;
            spr_en_q <= inbox1_q;
        end
    end

    assign spr_x        = spr_x_q;
    assign spr_y        = spr_y_q;
    assign spr_en       = spr_en_q;
    assign coin_collect = collect_q;
    assign coin_count   = count_q;
    assign coin_x       = coin_x_q;
    assign coin_y       = coin_y_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_ctrl
// Purpose  : Self-checking bench for coin_ctrl with queue-based scoreboards
// Revision : 1.0  initial release
// ============================================================================
module tb_coin_ctrl;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        game_run;
    logic [10:0] vga_x, vga_y;
    logic [10:0] bird_x, bird_y;
    logic [10:0] spr_x, spr_y;
    logic        spr_en;
    logic        coin_collect;
    logic [7:0]  coin_count;
    logic [10:0] coin_x, coin_y;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side model of the respawn height generator
    logic [7:0] m_lfsr, m_lfsr_prev;

    // Expected-state tracking
    int cx, cy, exp_cnt;

    typedef struct {
        logic [10:0] sx;
        logic        en;
    } rexp_t;

    rexp_t       q_rx[$];
    logic [10:0] q_ry[$];
    logic        q_col[$];

    coin_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .game_run     (game_run),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .bird_x       (bird_x),
        .bird_y       (bird_y),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_en       (spr_en),
        .coin_collect (coin_collect),
        .coin_count   (coin_count),
        .coin_x       (coin_x),
        .coin_y       (coin_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        m_lfsr_prev <= m_lfsr;
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // One frame tick: pulse high for one edge, then one idle edge; collect
    // expectations for both edges are queued up front and retired as sampled.
    task automatic tick(input logic exp_col);
        logic e;
        q_col.push_back(exp_col);
        q_col.push_back(1'b0);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        e = q_col.pop_front();
        n_checks++;
        if (coin_collect !== e) begin
            n_errors++;
            $display("FAIL collect_edge1: got %b exp %b at x=%0d", coin_collect, e, coin_x);
        end
        @(posedge clk); #1;
        e = q_col.pop_front();
        n_checks++;
        if (coin_collect !== e) begin
            n_errors++;
            $display("FAIL collect_edge2: got %b exp %b at x=%0d", coin_collect, e, coin_x);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        n_checks++;
        if (coin_x !== 11'(ex) || coin_y !== 11'(ey)) begin
            n_errors++;
            $display("FAIL %s: got (%0d,%0d) exp (%0d,%0d)", tag, coin_x, coin_y, ex, ey);
        end
    endtask

    task automatic check_count(input string tag);
        n_checks++;
        if (coin_count !== 8'(exp_cnt)) begin
            n_errors++;
            $display("FAIL %s: count got %0d exp %0d", tag, coin_count, exp_cnt);
        end
    endtask

    // Sweep scan positions around (bx,by); spr_y retires after 1 edge, spr_x/spr_en after 2.
    task automatic test_render(input int bx, input int by, input logic vis, input string tag);
        int ox[10] = '{0, 15, 16, -1, 3, 0, 15, 7, 15, 8};
        int oy[10] = '{0, 15, 0, 0, 7, 16, -1, 5, 0, 15};
        logic [10:0] vx, vy, dx, dy, ey;
        logic        inb;
        rexp_t       r;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                vx = 11'(bx + ox[k]);
                vy = 11'(by + oy[k]);
                vga_x = vx;
                vga_y = vy;
                dx  = vx - 11'(bx);
                dy  = vy - 11'(by);
                inb = vis && (dx < 11'd16) && (dy < 11'd16);
                q_ry.push_back(inb ? dy : 11'h7FF);
                r.sx = inb ? dx : 11'h7FF;
                r.en = inb;
                q_rx.push_back(r);
            end
            @(posedge clk); #1;
            if (k < 10) begin
                ey = q_ry.pop_front();
                n_checks++;
                if (spr_y !== ey) begin
                    n_errors++;
                    $display("FAIL %s spr_y[%0d]: got %h exp %h", tag, k, spr_y, ey);
                end
            end
            if (k > 0) begin
                r = q_rx.pop_front();
                n_checks++;
                if (spr_x !== r.sx || spr_en !== r.en) begin
                    n_errors++;
                    $display("FAIL %s spr_x/en[%0d]: got %h/%b exp %h/%b",
                             tag, k - 1, spr_x, spr_en, r.sx, r.en);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (spr_x !== 11'h7FF || spr_y !== 11'h7FF || spr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_render: got %h %h %b exp 7ff 7ff 0", spr_x, spr_y, spr_en);
        end
        n_checks++;
        if (coin_collect !== 1'b0 || coin_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_score: got %b %0d exp 0 0", coin_collect, coin_count);
        end
        check_pos("reset_pos", 640, 64);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_pos("idle_hold", 640, 64);
    endtask

    task automatic test_spawn();
        game_run = 1'b1;
        @(posedge clk); #1;
        check_pos("spawn_cycle", 640, 64);
        @(posedge clk); #1;
        cx = 640;
        cy = 64 + int'(m_lfsr_prev);
        check_pos("spawn_loaded", cx, cy);
    endtask

    task automatic test_scroll();
        for (int i = 0; i < 10; i++) tick(1'b0);
        cx = 620;
        check_pos("scroll10", cx, cy);
        check_count("scroll_count");
    endtask

    task automatic test_overlap();
        bird_x = 11'(cx - 24);
        bird_y = 11'(cy + 15);
        tick(1'b0);
        cx -= 2;
        check_pos("near_miss", cx, cy);
        bird_x = 11'(cx - 23);
        bird_y = 11'(cy + 15);
        tick(1'b1);
        exp_cnt = 1;
        check_count("corner_collect");
        check_pos("collect_hold", cx, cy);
        bird_x = 11'd0;
        bird_y = 11'd0;
        test_render(cx, cy, 1'b0, "hidden_render");
        for (int i = 0; i < 59; i++) tick(1'b0);
        check_pos("hide59", cx, cy);
        tick(1'b0);
        cx = 640;
        cy = 64 + int'(m_lfsr_prev);
        check_pos("respawn60", cx, cy);
    endtask

    task automatic test_exit();
        for (int i = 0; i < 319; i++) tick(1'b0);
        cx = 2;
        check_pos("scroll_to_2", cx, cy);
        tick(1'b0);
        check_pos("exit_hold", cx, cy);
        check_count("exit_nocount");
        test_render(cx, cy, 1'b0, "exit_render");
        for (int i = 0; i < 59; i++) tick(1'b0);
        check_pos("exit_hide59", cx, cy);
        tick(1'b0);
        cx = 640;
        cy = 64 + int'(m_lfsr_prev);
        check_pos("exit_respawn", cx, cy);
    endtask

    task automatic test_freeze();
        bird_x = 11'(cx);
        bird_y = 11'(cy);
        game_run = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check_pos("freeze_pos", cx, cy);
        check_count("freeze_count");
        test_render(cx, cy, 1'b1, "freeze_render");
        game_run = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            bird_x = 11'(cx);
            bird_y = 11'(cy);
            tick(1'b1);
            if (exp_cnt < 255) exp_cnt++;
            check_count("sat_count");
            bird_x = 11'd0;
            bird_y = 11'd0;
            for (int j = 0; j < 60; j++) tick(1'b0);
            cx = 640;
            cy = 64 + int'(m_lfsr_prev);
        end
        check_pos("sat_respawn", cx, cy);
    endtask

    task automatic test_back_to_back_rst();
        vga_x = 11'(cx + 2);
        vga_y = 11'(cy + 3);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (spr_en !== 1'b1 || spr_x !== 11'd2 || spr_y !== 11'd3) begin
            n_errors++;
            $display("FAIL pre_rst_render: got %b %h %h exp 1 002 003", spr_en, spr_x, spr_y);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (spr_en !== 1'b0 || spr_x !== 11'h7FF || spr_y !== 11'h7FF) begin
            n_errors++;
            $display("FAIL midline_rst: got %b %h %h exp 0 7ff 7ff", spr_en, spr_x, spr_y);
        end
        exp_cnt = 0;
        check_count("rst_count");
        check_pos("rst_pos", 640, 64);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        game_run   = 1'b0;
        vga_x      = 11'd0;
        vga_y      = 11'd0;
        bird_x     = 11'd0;
        bird_y     = 11'd0;
        exp_cnt    = 0;
        cx         = 640;
        cy         = 64;
        @(posedge clk); #1;

        test_reset();
        test_spawn();
        test_scroll();
        test_render(cx, cy, 1'b1, "active_render");
        test_overlap();
        test_exit();
        test_freeze();
        test_saturation();
        test_back_to_back_rst();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
